// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple_adder processes the operands one
// nibble per clock, least significant first, with the carry held in a register.

module ripple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar k = 0; k < 4; k++) begin : g_fa
    assign s[k]   = a[k] ^ b[k] ^ c[k];
    assign c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
  end

  assign cout = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // WIDTH must be a positive multiple of 4.
  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               out_valid_q;

  logic [3:0]         nib_a;
  logic [3:0]         nib_b;
  logic [3:0]         nib_s;
  logic               nib_cout;
  logic               accept;
  logic               last_nib;

  // Nibble select: explicit mux over constant slices keeps every index in range.
  always_comb begin
    nib_a = 4'd0;
    nib_b = 4'd0;
    for (int k = 0; k < N; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib_a = a_q[4*k +: 4];
        nib_b = b_q[4*k +: 4];
      end
    end
  end

  ripple_adder u_ripple (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout)
  );

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_nib = (state_q == ADD) && (idx_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ADD;
      ADD:     if (last_nib)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: plain data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Control state, carry chain and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        ADD: begin
          carry_q <= nib_cout;
          for (int k = 0; k < N; k++) begin
            if (idx_q == IDX_W'(k)) sum_q[4*k +: 4] <= nib_s;
          end
          if (last_nib) begin
            cout_q      <= nib_cout;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a WIDTH=16 instance and a WIDTH=4
// instance, checked with immediate assertions against hand-computed results.

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        iv16, ir16, ov16, or16, cin16, cout16, busy16;
  logic [15:0] a16, b16, sum16;

  logic        iv4, ir4, ov4, or4, cin4, cout4, busy4;
  logic [3:0]  a4, b4, sum4;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .cin       (cin16),
    .out_valid (ov16),
    .out_ready (or16),
    .sum       (sum16),
    .cout      (cout16),
    .busy      (busy16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (ov4),
    .out_ready (or4),
    .sum       (sum4),
    .cout      (cout4),
    .busy      (busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=16 operation: accept, watch latency and flags, hold in DONE, release.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic ec, input string tag,
                      input int hold, input bit pulse);
    int lat;
    iv16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    @(posedge clk); #1;
    iv16 = 1'b0;
    check({tag, ":ready_after_accept"}, ir16, 0);
    check({tag, ":busy_after_accept"}, busy16, 1);
    if (pulse) begin
      iv16 = 1'b1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1;
    end
    lat = 0;
    while (ov16 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      iv16 = 1'b0; a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0;
      lat++;
      check({tag, ":busy_in_add"}, busy16, 1);
      check({tag, ":ready_in_add"}, ir16, 0);
    end
    check({tag, ":latency"}, lat, 4);
    check({tag, ":sum"}, sum16, es);
    check({tag, ":cout"}, cout16, ec);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, ov16, 1);
      check({tag, ":hold_sum"}, sum16, es);
      check({tag, ":hold_cout"}, cout16, ec);
      check({tag, ":hold_ready"}, ir16, 0);
    end
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    check({tag, ":valid_after_hs"}, ov16, 0);
    check({tag, ":ready_after_hs"}, ir16, 1);
    check({tag, ":busy_after_hs"}, busy16, 0);
    check({tag, ":sum_kept"}, sum16, es);
    check({tag, ":cout_kept"}, cout16, ec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    iv4  = 1'b0; or4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;
    #3;
    // Reset state while held
    check("rst:in_ready", ir16, 1);
    check("rst:out_valid", ov16, 0);
    check("rst:busy", busy16, 0);
    check("rst:sum", sum16, 0);
    check("rst:cout", cout16, 0);
    check("rst4:in_ready", ir4, 1);
    check("rst4:out_valid", ov4, 0);
    @(posedge clk); #1;
    check("rst:in_ready_held", ir16, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle:no_accept", busy16, 0);

    op16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "basic", 0, 0);
    op16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "chain1", 0, 0);
    op16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "chain2", 0, 0);
    op16(16'hE6D8, 16'h9373, 1'b1, 16'h7A4C, 1'b1, "ovf1", 0, 0);
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ovf2", 0, 0);
    op16(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, "backpr", 5, 0);
    op16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "pulse", 0, 1);

    // Reset in the middle of ADD
    iv16 = 1'b1; a16 = 16'h8888; b16 = 16'h8888; cin16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst:busy_before", busy16, 1);
    rst_n = 1'b0;
    #1;
    check("midrst:out_valid", ov16, 0);
    check("midrst:sum", sum16, 0);
    check("midrst:cout", cout16, 0);
    check("midrst:busy", busy16, 0);
    check("midrst:in_ready", ir16, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "after_rst", 0, 0);

    // WIDTH=4 instance
    iv4 = 1'b1; a4 = 4'hD; b4 = 4'h7; cin4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    check("w4:busy", busy4, 1);
    check("w4:in_ready", ir4, 0);
    lat = 0;
    while (ov4 !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w4:latency", lat, 1);
    check("w4:sum", sum4, 4'h5);
    check("w4:cout", cout4, 1);
    or4 = 1'b1;
    @(posedge clk); #1;
    or4 = 1'b0;
    check("w4:valid_after_hs", ov4, 0);
    check("w4:ready_after_hs", ir4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
